// File: rtl/branch_pc_unit_if.sv
// Bundle between the fetch/decode/execute pipeline and branch_pc_unit.
// master drives the requests; slave is the unit that answers them.
interface branch_pc_unit_if #(
    parameter int XLEN = 64
);
    logic            stall;
    logic            predRedirect;
    logic [XLEN-1:0] predTarget;
    logic            brValid;
    logic            jump;
    logic [2:0]      brType;
    logic            brPredTaken;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] brPC;
    logic [XLEN-1:0] immediateValue;
    logic [XLEN-1:0] lookupPC;
    logic            predTaken;
    logic [XLEN-1:0] fetchPC;
    logic            flush;
    logic [31:0]     mispredictCount;

    modport master (
        output stall, predRedirect, predTarget,
        output brValid, jump, brType, brPredTaken,
        output rs1Data, rs2Data, brPC, immediateValue,
        output lookupPC,
        input  predTaken, fetchPC, flush, mispredictCount
    );

    modport slave (
        input  stall, predRedirect, predTarget,
        input  brValid, jump, brType, brPredTaken,
        input  rs1Data, rs2Data, brPC, immediateValue,
        input  lookupPC,
        output predTaken, fetchPC, flush, mispredictCount
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch PC sequencing, branch resolution and a bimodal
// 2-bit direction predictor indexed by PC[IDXW+1:2].
module branch_pc_unit #(
    parameter int              XLEN      = 64,
    parameter int              BHT_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input logic             clk,
    input logic             reset,
    branch_pc_unit_if.slave bus
);
    localparam int IDXW = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_type_e;

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_flush;
    logic [31:0]     r_mis_cnt;
    logic [1:0]      r_bht [BHT_DEPTH];

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fall;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_next_pc;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic            w_actual;
    logic            w_mispredict;
    logic            w_bht_we;
    logic [IDXW-1:0] w_lookup_idx;
    logic [IDXW-1:0] w_upd_idx;
    logic [1:0]      w_bht_cur;
    logic [1:0]      w_bht_nxt;
    logic            w_unused;

    assign w_target = bus.brPC + (bus.immediateValue << 1);
    assign w_fall   = bus.brPC + XLEN'(4);
    assign w_seq_pc = r_fetch_pc + XLEN'(4);

    assign w_eq  = (bus.rs1Data == bus.rs2Data);
    assign w_lt  = ($signed(bus.rs1Data) < $signed(bus.rs2Data));
    assign w_ltu = (bus.rs1Data < bus.rs2Data);

    // Reserved encodings 010/011 fall into the default: never taken.
    always_comb begin
        w_cond = 1'b0;
        case (bus.brType)
            BR_EQ:   w_cond = w_eq;
            BR_NE:   w_cond = ~w_eq;
            BR_LT:   w_cond = w_lt;
            BR_GE:   w_cond = ~w_lt;
            BR_LTU:  w_cond = w_ltu;
            BR_GEU:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_actual     = bus.jump | w_cond;
    assign w_mispredict = bus.brValid & (w_actual != bus.brPredTaken);

    // A mispredict outranks stall: the wrong path must be dropped.
    always_comb begin
        w_next_pc = w_seq_pc;
        if (w_mispredict) begin
            w_next_pc = w_actual ? w_target : w_fall;
        end else if (bus.stall) begin
            w_next_pc = r_fetch_pc;
        end else if (bus.predRedirect) begin
            w_next_pc = bus.predTarget;
        end
    end

    assign w_lookup_idx = bus.lookupPC[IDXW+1:2];
    assign w_upd_idx    = bus.brPC[IDXW+1:2];
    assign w_bht_we     = bus.brValid & ~bus.jump;
    assign w_bht_cur    = r_bht[w_upd_idx];

    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (w_actual) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_nxt = w_bht_cur + 2'b01;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_nxt = w_bht_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_flush    <= 1'b0;
            r_mis_cnt  <= '0;
        end else begin
            r_fetch_pc <= w_next_pc;
            r_flush    <= w_mispredict;
            r_mis_cnt  <= r_mis_cnt + {31'd0, w_mispredict};
        end
    end

    // Weakly not-taken start so one taken outcome flips the prediction.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_we) begin
            r_bht[w_upd_idx] <= w_bht_nxt;
        end
    end

    assign bus.predTaken       = r_bht[w_lookup_idx][1];
    assign bus.fetchPC         = r_fetch_pc;
    assign bus.flush           = r_flush;
    assign bus.mispredictCount = r_mis_cnt;

    assign w_unused = &{1'b0, bus.lookupPC[XLEN-1:IDXW+2],
                        bus.lookupPC[1:0]};
endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
- REQ-001: Parameter XLEN, default 64: width of every address and operand.
- REQ-002: Parameter BHT_DEPTH, default 16: number of 2-bit predictor entries; SHALL be a power of 2, at least 2. IDXW = log2(BHT_DEPTH).
- REQ-003: Parameter RESET_PC, default 0: fetch address loaded on reset.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: stall  input  1  hold fetchPC.
- REQ-007: predRedirect  input  1  decode requests a predicted-taken redirect.
- REQ-008: predTarget  input  XLEN  target for predRedirect.
- REQ-009: brValid  input  1  a branch or jump resolves this cycle.
- REQ-010: jump  input  1  the resolving instruction is unconditional (qualified by brValid).
- REQ-011: brType  input  3  condition: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
- REQ-012: brPredTaken  input  1  direction predicted for the resolving branch.
- REQ-013: rs1Data, rs2Data  input  XLEN  compare operands.
- REQ-014: brPC  input  XLEN  PC of the resolving branch.
- REQ-015: immediateValue  input  XLEN  halfword branch offset.
- REQ-016: lookupPC  input  XLEN  address to predict.
- REQ-017: predTaken  output  1  prediction for lookupPC (combinational).
- REQ-018: fetchPC  output  XLEN  registered fetch address.
- REQ-019: flush  output  1  registered one-cycle mispredict pulse.
- REQ-020: mispredictCount  output  32  registered count of mispredicts.

Function
- REQ-021: Target = brPC + (immediateValue << 1); fall-through = brPC + 4; both modulo 2^XLEN.
- REQ-022: LT/GE SHALL compare signed, LTU/GEU unsigned; brType 010 and 011 SHALL resolve not-taken.
- REQ-023: actualTaken = jump OR the brType condition holds.
- REQ-024: mispredict = brValid AND (actualTaken != brPredTaken).
- REQ-025: fetchPC next-value priority: reset -> RESET_PC; mispredict -> (actualTaken ? target : fall-through); stall -> hold; predRedirect -> predTarget; otherwise fetchPC + 4, wrapping.
- REQ-026: flush SHALL be 1 in the cycle after a mispredict edge and 0 otherwise.
- REQ-027: mispredictCount SHALL increment by 1 per mispredict and wrap from 2^32-1 to 0.
- REQ-028: BHT index = PC[IDXW+1:2]. predTaken SHALL be bit 1 of the entry that lookupPC indexes.
- REQ-029: On brValid AND NOT jump, the entry that brPC indexes SHALL increment when actualTaken is 1 and decrement otherwise, saturating at 11 and 00.
- REQ-030: Jumps SHALL NOT update the BHT.
- REQ-031: A read and an update of the same index in the same cycle SHALL return the pre-update value.
- REQ-032: Mispredict redirect SHALL apply even when stall is 1.

Reset
- REQ-033: Reset SHALL force fetchPC = RESET_PC, flush = 0, mispredictCount = 0 and every BHT entry = 01, overriding all other inputs in the same cycle.
- REQ-034: Reset asserted mid-operation SHALL discard any pending redirect or update.

Verification
- REQ-035: Reset, then 3 idle cycles -> fetchPC 0, 4, 8, 12; flush 0; predTaken 0 for any lookupPC.
- REQ-036: brValid, BEQ, rs1 = rs2 = 5, brPC 0x100, imm 0x10, brPredTaken 0 -> next fetchPC 0x120; flush 1 for exactly one cycle; mispredictCount 1.
- REQ-037: BLT with rs1 = -1, rs2 = 1 -> taken. BLTU with the same operands -> not taken; with brPredTaken 1 the next fetchPC is brPC + 4.
- REQ-038: Three taken updates to index 3, then lookupPC 0x0C -> predTaken 1 and the entry holds 11; a fourth taken update keeps it at 11. Four not-taken updates -> 00.
- REQ-039: stall, predRedirect and a mispredict in the same cycle -> the mispredict target wins. stall alone -> fetchPC held. predRedirect alone -> fetchPC = predTarget.
- REQ-040: XLEN 32, fetchPC 0xFFFFFFFC, no events -> next fetchPC 0x0. Reset asserted together with a mispredict -> fetchPC RESET_PC, flush 0.
